serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Sequencer that time-shares a single one-bit adder cell across an N-bit addition or subtraction. The cell is two half adders (s = a^b, ca = a&b) plus an OR for carry-out. The block accepts operands over a valid/ready handshake and feeds the cell LSB-first, one bit per cycle, through a registered carry. It then presents the N-bit result and carry-out over a second valid/ready handshake. It is the area-minimal alternative to a ripple adder in the arithmetic datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (computed as a + ~b + 1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out; when sub=1, 1 means no borrow (a >= b unsigned).
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a into shift reg A, and b (or ~b if sub) into shift reg B.
  - Carry reg <= sub ? 1 : cin. Bit counter <= 0. Go to RUN.
- RUN:
  - Each cycle the cell adds A[0], B[0] and the carry reg.
  - The sum bit shifts into the result reg MSB-first (shift right), so bit i lands at sum[i] after WIDTH shifts.
  - Carry reg <= cell carry-out. A and B shift right. Counter increments.
  - When counter = WIDTH-1, that edge performs the final bit, loads cout, and goes to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: go to IDLE.
  - in_ready=0 throughout DONE, so there is no same-cycle accept; in_valid is ignored outside IDLE.
- Operands are captured only at the accept edge. Changes on a, b, cin, sub after that edge have no effect.
- After DONE, sum and cout retain the last result until the next accept edge. At the accept edge they clear to 0.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of the full sum.
- Counter width is clog2(WIDTH).

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, counter=0, carry=0.
- Reset acts asynchronously from any state, including mid-RUN: the state returns to IDLE and the partial result is discarded.
- Latency: with accept at edge E0, out_valid rises after edge E0+WIDTH.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH-1 further RUN edges, a DONE cycle, and a return to IDLE.
- in_ready falls the cycle after the accept edge and rises the cycle after the out_valid & out_ready edge.
- Backpressure: out_valid stays high and sum/cout stay constant for any number of cycles with out_ready=0.
- out_ready high while out_valid=0 has no effect.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Test plan
- Add: WIDTH=8, a=0x0F, b=0x01, cin=0, sub=0 -> sum=0x10, cout=0, out_valid exactly 8 cycles after the accept edge.
- Overflow with carry-in: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Also a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- Subtract:
  - a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0.
  - a=0x05, b=0x07, sub=1, cin=1 -> still sum=0xFE, cout=0 (cin ignored).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands -> out_valid=1, sum/cout unchanged, in_ready=0, busy=1; then out_ready=1 for one cycle -> IDLE, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst on the 3rd RUN cycle of a=0xAA, b=0x55 -> out_valid=0, sum=0, busy=0 immediately. After deassert, a new op a=0x10, b=0x20 yields sum=0x30, cout=0 with full latency.
- Operand stability: change a and b on the cycle after the accept edge -> result reflects the latched values only.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial adder/subtractor: one full-adder cell (two half adders + OR) is
// reused LSB-first across WIDTH cycles, with valid/ready on both operand and result sides.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic w_accept;
  logic w_last;
  logic w_ha1_s;
  logic w_ha1_c;
  logic w_ha2_s;
  logic w_ha2_c;
  logic w_cell_co;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // The shared cell: operand bits meet in the first half adder, the registered carry in the second.
  assign w_ha1_s   = r_a[0] ^ r_b[0];
  assign w_ha1_c   = r_a[0] & r_b[0];
  assign w_ha2_s   = w_ha1_s ^ r_carry;
  assign w_ha2_c   = w_ha1_s & r_carry;
  assign w_cell_co = w_ha1_c | w_ha2_c;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)  w_next = S_RUN;
      S_RUN:  if (w_last)    w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_RUN:  busy     = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B at capture and seed the carry with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum   <= {w_ha2_s, r_sum[WIDTH-1:1]};
      r_carry <= w_cell_co;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_cell_co;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8): handshakes, latency, add/sub
// results, backpressure, mid-run reset and operand capture.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one operand set, optionally scrambles the inputs right after the accept
  // edge, and counts edges until out_valid (lat = -1 if it never rises).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub, input bit scramble,
                        output int lat, output logic ir_after);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    ir_after = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    if (scramble) begin
      a = ~ta; b = ta ^ tb_v ^ 8'h5A; cin = ~tcin; sub = ~tsub;
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h cout=%b, want rdy=1 vld=0 busy=0 sum=00 cout=0",
               in_ready, out_valid, busy, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_out_ready: got vld=%b rdy=%b busy=%b, want vld=0 rdy=1 busy=0",
                 out_valid, in_ready, busy);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_add();
    int   lat;
    logic ir;
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, lat, ir);
    checks++;
    if (ir !== 1'b0) begin
      failures++;
      $display("FAIL add_in_ready_fall: got in_ready=%b after accept, want 0", ir);
    end
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL add_latency: got %0d edges, want 8", lat);
    end
    checks++;
    if (sum !== 8'h10 || cout !== 1'b0) begin
      failures++;
      $display("FAIL add_0f_01: got sum=%h cout=%b, want sum=10 cout=0", sum, cout);
    end
    consume();
  endtask

  task automatic test_overflow();
    int   lat;
    logic ir;
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, lat, ir);
    checks++;
    if (sum !== 8'hFF || cout !== 1'b1 || lat !== 8) begin
      failures++;
      $display("FAIL ovf_ff_ff_c1: got sum=%h cout=%b lat=%0d, want sum=ff cout=1 lat=8", sum, cout, lat);
    end
    consume();
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, lat, ir);
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      failures++;
      $display("FAIL ovf_ff_01: got sum=%h cout=%b, want sum=00 cout=1", sum, cout);
    end
    consume();
  endtask

  task automatic test_subtract();
    int   lat;
    logic ir;
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0, lat, ir);
    checks++;
    if (sum !== 8'h02 || cout !== 1'b1) begin
      failures++;
      $display("FAIL sub_07_05: got sum=%h cout=%b, want sum=02 cout=1", sum, cout);
    end
    consume();
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, lat, ir);
    checks++;
    if (sum !== 8'hFE || cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_05_07: got sum=%h cout=%b, want sum=fe cout=0", sum, cout);
    end
    consume();
    run_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0, lat, ir);
    checks++;
    if (sum !== 8'hFE || cout !== 1'b0) begin
      failures++;
      $display("FAIL sub_cin_ignored: got sum=%h cout=%b, want sum=fe cout=0", sum, cout);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int   lat;
    logic ir;
    run_op(8'h33, 8'h11, 1'b0, 1'b0, 1'b0, lat, ir);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a = W'($urandom);
      b = W'($urandom);
      sub = ~sub;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || sum !== 8'h44 || cout !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d: got vld=%b sum=%h cout=%b rdy=%b busy=%b, want vld=1 sum=44 cout=0 rdy=0 busy=1",
                 i, out_valid, sum, cout, in_ready, busy);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h44) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b vld=%b busy=%b sum=%h, want rdy=1 vld=0 busy=0 sum=44",
               in_ready, out_valid, busy, sum);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int   lat;
    logic ir;
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_run: got vld=%b sum=%h busy=%b rdy=%b, want vld=0 sum=00 busy=0 rdy=1",
               out_valid, sum, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, lat, ir);
    checks++;
    if (sum !== 8'h30 || cout !== 1'b0 || lat !== 8) begin
      failures++;
      $display("FAIL rst_recover: got sum=%h cout=%b lat=%0d, want sum=30 cout=0 lat=8", sum, cout, lat);
    end
    consume();
  endtask

  task automatic test_operand_stability();
    int   lat;
    logic ir;
    run_op(8'h3C, 8'h42, 1'b0, 1'b0, 1'b1, lat, ir);
    checks++;
    if (sum !== 8'h7E || cout !== 1'b0) begin
      failures++;
      $display("FAIL stable_add: got sum=%h cout=%b, want sum=7e cout=0", sum, cout);
    end
    consume();
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b1, lat, ir);
    checks++;
    if (sum !== 8'h7F || cout !== 1'b1) begin
      failures++;
      $display("FAIL stable_sub: got sum=%h cout=%b, want sum=7f cout=1", sum, cout);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic ir;
    run_op(8'hC8, 8'h64, 1'b0, 1'b0, 1'b0, lat, ir);
    consume();
    run_op(8'h01, 8'h02, 1'b1, 1'b0, 1'b0, lat, ir);
    checks++;
    if (sum !== 8'h04 || cout !== 1'b0 || lat !== 8) begin
      failures++;
      $display("FAIL b2b_second: got sum=%h cout=%b lat=%0d, want sum=04 cout=0 lat=8", sum, cout, lat);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_subtract();
    test_backpressure();
    test_reset_mid_run();
    test_operand_stability();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
